// File: rtl/systolic_edge_feeder_pkg.sv
// Shared constants and types for the systolic edge feeder.
// N lanes per edge, DATA_WIDTH-bit operands, up to K_MAX slices per tile,
// DRAIN idle cycles after the skewed stream before tile_done.
package systolic_edge_feeder_pkg;

  localparam int N          = 4;
  localparam int DATA_WIDTH = 8;
  localparam int K_MAX      = 8;
  localparam int DRAIN      = 2 * N;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(K_MAX);

  // Counter widths
  localparam int KW  = $clog2(K_MAX + 1);  // slice count 0..K_MAX
  localparam int IW  = $clog2(K_MAX);      // buffer index
  localparam int TW  = $clog2(K_MAX + N);  // stream step 0..K_MAX+N-2
  localparam int DCW = $clog2(DRAIN + 1);  // drain step

  typedef logic [N*DATA_WIDTH-1:0] slice_t;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/systolic_edge_feeder_edge_skew_buf.sv
// One operand's tile buffer (K_MAX slices of N lanes) with a diagonally
// skewed, registered read. Lane i of the output carries slice (t-i) when
// that index lies inside [0, len), otherwise zero.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears the edge only)
//   we_i           write slice wr_data_i at wr_idx_i
//   rd_en_i        next cycle is a stream cycle
//   t_i, len_i     stream step and tile length for the next cycle
//   edge_o         registered skewed edge
module systolic_edge_feeder_edge_skew_buf
  import systolic_edge_feeder_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [IW-1:0] wr_idx_i,
  input  slice_t        wr_data_i,
  input  logic          rd_en_i,
  input  logic [TW-1:0] t_i,
  input  logic [KW-1:0] len_i,
  output slice_t        edge_o
);

  slice_t        mem_q [K_MAX];
  slice_t        edge_q, edge_d;
  logic [TW-1:0] idx [N];
  slice_t        row [N];

  // Storage is never cleared; entries beyond the tile length are never read.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  always_comb begin
    edge_d = '0;
    for (int i = 0; i < N; i++) begin
      idx[i] = t_i - TW'(i);
      // The final slice of a tile is written on the same edge that loads
      // the first stream step, so a write to the slot being read bypasses.
      row[i] = (we_i && (TW'(wr_idx_i) == idx[i])) ? wr_data_i
                                                   : mem_q[idx[i][IW-1:0]];
      if (rd_en_i && (t_i >= TW'(i)) && (idx[i] < TW'(len_i)))
        edge_d[i*DATA_WIDTH +: DATA_WIDTH] = row[i][i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) edge_q <= '0;
    else       edge_q <= edge_d;
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/systolic_edge_feeder.sv
// Buffers one tile of A column-slices and B row-slices, then streams them
// diagonally skewed (lane i delayed i cycles) onto the left and top edges of
// an N x N PE array, followed by DRAIN idle cycles and a tile_done pulse.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   ld_valid_i / ld_ready_o   load handshake
//   ld_a_i, ld_b_i            slice data, lane i = bits [i*DW +: DW]
//   ld_last_i                 final slice of the tile
//   a_edge_o, b_edge_o        registered skewed edges
//   edge_valid_o              stream in progress (skew zeros included)
//   busy_o                    STREAM or DRAIN
//   tile_done_o               one-cycle pulse in the last DRAIN cycle
//   k_len_o                   slice count of the current/last tile
//   state_o                   FSM state, for observation
module systolic_edge_feeder
  import systolic_edge_feeder_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  input  slice_t        ld_a_i,
  input  slice_t        ld_b_i,
  input  logic          ld_last_i,
  output slice_t        a_edge_o,
  output slice_t        b_edge_o,
  output logic          edge_valid_o,
  output logic          busy_o,
  output logic          tile_done_o,
  output logic [KW-1:0] k_len_o,
  output state_e        state_o
);

  state_e         state_q, state_d;
  logic [KW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  k_len_q, k_len_d;
  logic [TW-1:0]  t_q, t_d;
  logic [DCW-1:0] drn_q, drn_d;
  logic           xfer;
  logic           rd_en;

  // Handshake: a slice moves on a clock edge where ld_valid_i && ld_ready_o.
  // ld_ready_o depends on state only, so the source must hold ld_a_i, ld_b_i
  // and ld_last_i stable while ld_valid_i is high and ld_ready_o is low.
  assign ld_ready_o = (state_q == ST_LOAD);
  assign xfer       = ld_valid_i && ld_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      k_len_q <= '0;
      t_q     <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_len_q <= k_len_d;
      t_q     <= t_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_len_d = k_len_q;
    t_d     = t_q;
    drn_d   = drn_q;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          // A full buffer ends the tile even without ld_last_i.
          if (ld_last_i || (cnt_q == KW'(K_MAX - 1))) begin
            state_d = ST_STREAM;
            k_len_d = cnt_q + 1'b1;
            t_d     = '0;
          end
        end
      end
      ST_STREAM: begin
        // Last lane finishes k_len+N-1 steps after the first.
        if (t_q == TW'(k_len_q) + TW'(N - 2)) begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drn_q == DCW'(DRAIN - 1)) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Edge registers are loaded with the value for the coming cycle.
  assign rd_en = (state_d == ST_STREAM);

  systolic_edge_feeder_edge_skew_buf u_a_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (xfer),
    .wr_idx_i  (cnt_q[IW-1:0]),
    .wr_data_i (ld_a_i),
    .rd_en_i   (rd_en),
    .t_i       (t_d),
    .len_i     (k_len_d),
    .edge_o    (a_edge_o)
  );

  systolic_edge_feeder_edge_skew_buf u_b_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (xfer),
    .wr_idx_i  (cnt_q[IW-1:0]),
    .wr_data_i (ld_b_i),
    .rd_en_i   (rd_en),
    .t_i       (t_d),
    .len_i     (k_len_d),
    .edge_o    (b_edge_o)
  );

  assign edge_valid_o = (state_q == ST_STREAM);
  assign busy_o       = (state_q != ST_LOAD);
  assign tile_done_o  = (state_q == ST_DRAIN) && (drn_q == DCW'(DRAIN - 1));
  assign k_len_o      = k_len_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_systolic_edge_feeder.sv
module tb_systolic_edge_feeder;
  import systolic_edge_feeder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ld_valid, ld_ready, ld_last;
  slice_t        ld_a, ld_b, a_edge, b_edge;
  logic          edge_valid, busy, tile_done;
  logic [KW-1:0] k_len;
  state_e        state;

  systolic_edge_feeder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ld_valid_i   (ld_valid),
    .ld_ready_o   (ld_ready),
    .ld_a_i       (ld_a),
    .ld_b_i       (ld_b),
    .ld_last_i    (ld_last),
    .a_edge_o     (a_edge),
    .b_edge_o     (b_edge),
    .edge_valid_o (edge_valid),
    .busy_o       (busy),
    .tile_done_o  (tile_done),
    .k_len_o      (k_len),
    .state_o      (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];

  slice_t model_a [K_MAX];
  slice_t model_b [K_MAX];

  // ---------------- 4x4 output-stationary PE grid ----------------
  logic [DATA_WIDTH-1:0] pa [N][N];
  logic [DATA_WIDTH-1:0] pb [N][N];
  int                    acc [N][N];
  logic                  pe_clr;

  always @(posedge clk) begin
    logic [DATA_WIDTH-1:0] ain, bin;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ain = (j == 0) ? a_edge[i*DATA_WIDTH +: DATA_WIDTH] : pa[i][j-1];
        bin = (i == 0) ? b_edge[j*DATA_WIDTH +: DATA_WIDTH] : pb[i-1][j];
        pa[i][j] <= ain;
        pb[i][j] <= bin;
        if (pe_clr) acc[i][j] <= 0;
        else        acc[i][j] <= acc[i][j] + int'(ain) * int'(bin);
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic slice_t skew(input bit use_b, input int len, input int t);
    slice_t r = '0;
    for (int i = 0; i < N; i++) begin
      if ((t - i) >= 0 && (t - i) < len) begin
        if (use_b) r[i*DATA_WIDTH +: DATA_WIDTH] = model_b[t-i][i*DATA_WIDTH +: DATA_WIDTH];
        else       r[i*DATA_WIDTH +: DATA_WIDTH] = model_a[t-i][i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return r;
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input slice_t a, input slice_t b, input logic last);
    int w = 0;
    ld_a = a; ld_b = b; ld_last = last; ld_valid = 1'b1;
    while (!ld_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ld_ready) check("send_ready_timeout", {63'd0, ld_ready}, 64'd1);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!tile_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("tile_done_seen", {63'd0, tile_done}, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    slice_t a;
    slice_t b;
    logic   v;
  } vec_t;
  vec_t tbl [8];

  initial begin
    slice_t a, b, mask;
    int cyc, w;
    int bmat [N][N];
    int amat [N][N];
    int ref_v;

    tbl[0] = '{32'h0000_0000, 32'h0000_0080, 1'b1};
    tbl[1] = '{32'h0000_010A, 32'h0000_8190, 1'b1};
    tbl[2] = '{32'h0002_0B14, 32'h0082_91A0, 1'b1};
    tbl[3] = '{32'h030C_151E, 32'h8392_A1B0, 1'b1};
    tbl[4] = '{32'h0D16_1F00, 32'h93A2_B100, 1'b1};
    tbl[5] = '{32'h1720_0000, 32'hA3B2_0000, 1'b1};
    tbl[6] = '{32'h2100_0000, 32'hB300_0000, 1'b1};
    tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0};

    rst = 1'b1; ld_valid = 1'b0; ld_a = '0; ld_b = '0; ld_last = 1'b0; pe_clr = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ld_ready",   {63'd0, ld_ready},   64'd1);
    check("rst_a_edge",     {32'd0, a_edge},     64'd0);
    check("rst_b_edge",     {32'd0, b_edge},     64'd0);
    check("rst_busy",       {63'd0, busy},       64'd0);
    check("rst_edge_valid", {63'd0, edge_valid}, 64'd0);
    check("rst_tile_done",  {63'd0, tile_done},  64'd0);
    check("rst_k_len",      64'(k_len),          64'd0);
    check("rst_state",      64'(state),          64'(ST_LOAD));

    // k_len=4, A[k][i]=10k+i, B[k][j]=0x80+16k+j
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) begin
        a[i*DATA_WIDTH +: DATA_WIDTH] = 8'(10 * k + i);
        b[i*DATA_WIDTH +: DATA_WIDTH] = 8'(8'h80 + 16 * k + i);
      end
      send(a, b, k == 3);
    end
    check("t2_k_len", 64'(k_len), 64'd4);
    for (int v = 0; v < 8; v++) begin
      check($sformatf("t2_a_edge[%0d]", v), {32'd0, a_edge}, {32'd0, tbl[v].a});
      check($sformatf("t2_b_edge[%0d]", v), {32'd0, b_edge}, {32'd0, tbl[v].b});
      check($sformatf("t2_valid[%0d]", v), {63'd0, edge_valid}, {63'd0, tbl[v].v});
      @(negedge clk);
    end
    wait_done(cyc);
    check("t2_drain_remaining", 64'(cyc), 64'd6);
    check("t2_back_to_load", 64'(state), 64'(ST_LOAD));
    check("t2_ready_after", {63'd0, ld_ready}, 64'd1);

    // Single slice with ld_last
    send(32'h4433_2211, 32'h8877_6655, 1'b1);
    check("t3_k_len", 64'(k_len), 64'd1);
    for (int t = 0; t < N; t++) begin
      mask = 32'hFF << (8 * t);
      check($sformatf("t3_a_edge[%0d]", t), {32'd0, a_edge}, {32'd0, 32'h4433_2211 & mask});
      check($sformatf("t3_b_edge[%0d]", t), {32'd0, b_edge}, {32'd0, 32'h8877_6655 & mask});
      check($sformatf("t3_valid[%0d]", t), {63'd0, edge_valid}, 64'd1);
      @(negedge clk);
    end
    for (int d = 1; d <= DRAIN; d++) begin
      check($sformatf("t3_tile_done[%0d]", d), {63'd0, tile_done}, {63'd0, (d == DRAIN)});
      check($sformatf("t3_drain_valid[%0d]", d), {63'd0, edge_valid}, 64'd0);
      check($sformatf("t3_drain_busy[%0d]", d), {63'd0, busy}, 64'd1);
      @(negedge clk);
    end
    check("t3_ready_after", {63'd0, ld_ready}, 64'd1);

    // K_MAX slices without ld_last
    for (int k = 0; k < K_MAX; k++) begin
      for (int i = 0; i < N; i++) a[i*DATA_WIDTH +: DATA_WIDTH] = 8'(16 * k + i + 1);
      model_a[k] = a;
      model_b[k] = ~a;
      send(model_a[k], model_b[k], 1'b0);
    end
    check("t4_k_len", 64'(k_len), 64'(K_MAX));
    check("t4_ready_low", {63'd0, ld_ready}, 64'd0);
    for (int t = 0; t < K_MAX + N; t++) exp_q.push_back({skew(1'b0, K_MAX, t), skew(1'b1, K_MAX, t)});
    for (int t = 0; t < K_MAX + N; t++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      check($sformatf("t4_edges[%0d]", t), {a_edge, b_edge}, e);
      check($sformatf("t4_valid[%0d]", t), {63'd0, edge_valid}, {63'd0, (t < K_MAX + N - 1)});
      @(negedge clk);
    end
    wait_done(cyc);

    // Backpressure: slice offered during STREAM/DRAIN
    send(32'h0A0B_0C0D, 32'h0102_0304, 1'b1);
    ld_a = 32'hC1C2_C3C4; ld_b = 32'hD1D2_D3D4; ld_last = 1'b1; ld_valid = 1'b1;
    w = 0;
    while (!ld_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("t5_wait_cycles", 64'(w), 64'(N + DRAIN));
    @(negedge clk);
    ld_valid = 1'b0;
    check("t5_k_len", 64'(k_len), 64'd1);
    check("t5_a_edge0", {32'd0, a_edge}, 64'h0000_00C4);
    check("t5_b_edge0", {32'd0, b_edge}, 64'h0000_00D4);
    wait_done(cyc);
    check("t5_once_ready", {63'd0, ld_ready}, 64'd1);
    check("t5_once_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    check("t5_once_idle", {63'd0, busy}, 64'd0);

    // Reset mid-STREAM
    for (int k = 0; k < 4; k++) send(32'h5555_5555, 32'h6666_6666, k == 3);
    repeat (2) @(negedge clk);
    check("t6_pre_valid", {63'd0, edge_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_a_edge", {32'd0, a_edge}, 64'd0);
    check("t6_b_edge", {32'd0, b_edge}, 64'd0);
    check("t6_state",  64'(state), 64'(ST_LOAD));
    check("t6_busy",   {63'd0, busy}, 64'd0);
    check("t6_k_len",  64'(k_len), 64'd0);

    // End-to-end with PE grid: A = I, B random
    repeat (N + 1) @(negedge clk);
    pe_clr = 1'b1;
    @(negedge clk);
    pe_clr = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        amat[k][i] = (i == k) ? 1 : 0;
        bmat[k][i] = int'($urandom_range(0, 255));
        a[i*DATA_WIDTH +: DATA_WIDTH] = 8'(amat[k][i]);
        b[i*DATA_WIDTH +: DATA_WIDTH] = 8'(bmat[k][i]);
      end
      send(a, b, k == N - 1);
    end
    wait_done(cyc);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ref_v = 0;
        for (int k = 0; k < N; k++) ref_v += amat[k][i] * bmat[k][j];
        check($sformatf("t7_c[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(ref_v));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
